// File: rtl/vga_dac_pattern_driver.sv
// VGA timing generator and test-pattern source for a three-channel 8-bit video DAC.
// Every output is registered from the counter state of the previous cycle.
module vga_dac_pattern_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned BAR_W    = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic [7:0] level,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank,
    output logic       frame_start
);

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Ramp reads h_cnt[7:0] and checker reads v_cnt[5], so keep minimum widths.
    localparam int unsigned HW = ($clog2(HT) < 8) ? 8 : $clog2(HT);
    localparam int unsigned VW = ($clog2(VT) < 6) ? 6 : $clog2(VT);
    localparam int unsigned BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [2:0]    r_bar;
    logic [BW-1:0] r_bar_px;
    logic [1:0]    r_mode;
    logic [7:0]    r_red, r_green, r_blue;
    logic          r_hsync_n, r_vsync_n, r_blank, r_frame_start;

    logic          w_h_last, w_v_last, w_origin, w_visible, w_hs, w_vs, w_chk;
    logic [1:0]    w_mode;
    logic [7:0]    w_red, w_green, w_blue;

    always_comb begin
        w_h_last  = (r_h_cnt == HW'(HT - 1));
        w_v_last  = (r_v_cnt == VW'(VT - 1));
        w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);
        // The origin pixel already uses the freshly sampled mode.
        w_mode    = w_origin ? mode : r_mode;
        w_visible = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
        w_hs      = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
        w_vs      = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
        w_chk     = r_h_cnt[5] ^ r_v_cnt[5];
        w_red     = '0;
        w_green   = '0;
        w_blue    = '0;
        if (w_visible) begin
            unique case (w_mode)
                2'd0: begin
                    w_red   = level;
                    w_green = level;
                    w_blue  = level;
                end
                2'd1: begin
                    w_red   = r_h_cnt[7:0];
                    w_green = r_h_cnt[7:0];
                    w_blue  = r_h_cnt[7:0];
                end
                2'd2: begin
                    w_red   = r_bar[2] ? level : 8'h00;
                    w_green = r_bar[1] ? level : 8'h00;
                    w_blue  = r_bar[0] ? level : 8'h00;
                end
                default: begin
                    w_red   = w_chk ? level : 8'h00;
                    w_green = w_chk ? level : 8'h00;
                    w_blue  = w_chk ? level : 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_bar         <= '0;
            r_bar_px      <= '0;
            r_mode        <= '0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (ena) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end
            // Bar index counts whole bars within a line and saturates at white.
            if (w_h_last) begin
                r_bar    <= '0;
                r_bar_px <= '0;
            end else if (r_bar_px == BW'(BAR_W - 1)) begin
                r_bar_px <= '0;
                if (r_bar != 3'd7) begin
                    r_bar <= r_bar + 1'b1;
                end
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
            if (w_origin) begin
                r_mode <= mode;
            end
            r_red         <= w_red;
            r_green       <= w_green;
            r_blue        <= w_blue;
            r_hsync_n     <= ~w_hs;
            r_vsync_n     <= ~w_vs;
            r_blank       <= ~w_visible;
            r_frame_start <= w_origin;
        end
    end

    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;

endmodule
